// File: rtl/pressure_frame_tx.sv
// pressure_frame_tx: snapshots three 16-bit pressures on a start pulse and
// streams a 10-byte frame (header, sequence, payload, checksum) one byte per
// tx_vld / tx_done_sig handshake. Aborts on a per-byte timeout and counts
// start requests that arrive while a frame is in flight.
module pressure_frame_tx #(
  parameter logic [7:0] HDR0        = 8'h55,
  parameter logic [7:0] HDR1        = 8'hAA,
  parameter int         TIMEOUT_CYC = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] p1,
  input  logic [15:0] p2,
  input  logic [15:0] p3,
  output logic [7:0]  tx_data,
  output logic        tx_vld,
  input  logic        tx_done_sig,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err,
  output logic [7:0]  seq,
  output logic [7:0]  ovf_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [TW-1:0] tmo;

  // Snapshot of the frame content; data only, so no reset
  logic [15:0] cap_p1, cap_p2, cap_p3;
  logic [7:0]  cap_seq, cap_chk;

  // 8-bit wraparound sum of sequence number and the six payload bytes
  function automatic logic [7:0] checksum(input logic [7:0] s,
                                          input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [15:0] c);
    logic [7:0] acc;
    acc = s;
    acc = acc + a[15:8];
    acc = acc + a[7:0];
    acc = acc + b[15:8];
    acc = acc + b[7:0];
    acc = acc + c[15:8];
    acc = acc + c[7:0];
    return acc;
  endfunction

  // Byte i of the frame built from the captured snapshot
  function automatic logic [7:0] frame_byte(input logic [3:0] i);
    logic [7:0] b;
    case (i)
      4'd0:    b = HDR0;
      4'd1:    b = HDR1;
      4'd2:    b = cap_seq;
      4'd3:    b = cap_p1[15:8];
      4'd4:    b = cap_p1[7:0];
      4'd5:    b = cap_p2[15:8];
      4'd6:    b = cap_p2[7:0];
      4'd7:    b = cap_p3[15:8];
      4'd8:    b = cap_p3[7:0];
      default: b = cap_chk;
    endcase
    return b;
  endfunction

  // Capture pressures, sequence number and checksum when a frame is accepted
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      cap_p1  <= p1;
      cap_p2  <= p2;
      cap_p3  <= p3;
      cap_seq <= seq;
      cap_chk <= checksum(seq, p1, p2, p3);
    end
  end

  // Frame sequencer: byte handshake, timeout, sequence and overrun counting
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      tmo        <= '0;
      tx_data    <= '0;
      tx_vld     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      seq        <= '0;
      ovf_cnt    <= '0;
    end else begin
      tx_vld     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      if (start && state != S_IDLE && ovf_cnt != 8'hFF)
        ovf_cnt <= ovf_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          // Header byte is presented in the cycle right after start
          if (start) begin
            idx     <= '0;
            tx_data <= HDR0;
            tx_vld  <= 1'b1;
            busy    <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          tmo   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // tx_done_sig takes priority over a coinciding timeout
          if (tx_done_sig) begin
            if (idx == 4'd9) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
              seq        <= seq + 8'd1;
            end else begin
              idx     <= idx + 4'd1;
              tx_data <= frame_byte(idx + 4'd1);
              tx_vld  <= 1'b1;
              state   <= S_LOAD;
            end
          end else if (tmo == TMO_LAST) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pressure_frame_tx.sv
// tb_pressure_frame_tx: scoreboard bench for pressure_frame_tx. Expected frame
// bytes are queued when a frame is started; a monitor pops and compares on
// every tx_vld. A responder returns tx_done_sig a fixed latency after tx_vld.
module tb_pressure_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] p1 = '0, p2 = '0, p3 = '0;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_done_sig = 1'b0;
  logic        busy, frame_done, frame_err;
  logic [7:0]  seq, ovf_cnt;

  pressure_frame_tx #(.HDR0(8'h55), .HDR1(8'hAA), .TIMEOUT_CYC(50)) dut (
    .clk(clk), .rst(rst), .start(start), .p1(p1), .p2(p2), .p3(p3),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_done_sig(tx_done_sig),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
    .seq(seq), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mon_bytes = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int lat = 5;
  int resp_left = 1_000_000;
  int cd = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Responder: pulse tx_done_sig lat cycles after each tx_vld while enabled
  initial begin
    forever begin
      @(negedge clk);
      tx_done_sig = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) tx_done_sig = 1'b1;
      end
      if (tx_vld && resp_left > 0) begin
        cd = lat;
        resp_left--;
      end
    end
  end

  // Monitor: compare every presented byte against the scoreboard queue
  initial begin
    forever begin
      @(negedge clk);
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (tx_vld) begin
        mon_bytes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx_vld: got byte %0h expected no byte (cycle %0d)", tx_data, cyc);
        end else begin
          check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [79:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[79-8*i -: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: frame_done, 1: frame_err, 2: final tx_done_sig of frame starting at base
  task automatic wait_for(input int mode, input int maxc, input bit scramble, input int base);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if ((mode == 0 && frame_done) || (mode == 1 && frame_err) ||
          (mode == 2 && tx_done_sig && mon_bytes == base + 10)) begin
        got = 1'b1;
        break;
      end
      tick();
      if (scramble) begin
        p1 = 16'($urandom);
        p2 = 16'($urandom);
        p3 = 16'($urandom);
      end
    end
    check($sformatf("wait_mode%0d", mode), {31'h0, got}, 32'h1);
  endtask

  task automatic wait_bytes(input int target, input int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      if (mon_bytes == target) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("wait_bytes", {31'h0, got}, 32'h1);
  endtask

  initial begin
    int base;
    int t0;
    int d0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_tx_vld", {31'h0, tx_vld}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_seq", {24'h0, seq}, 32'h0);
    check("rst_ovf", {24'h0, ovf_cnt}, 32'h0);

    // Frame 1 with inputs scrambled every cycle after capture
    p1 = 16'h1234; p2 = 16'hABCD; p3 = 16'h00FF;
    push_vec(80'h55AA_0012_34AB_CD00_FFBD, 10);
    pulse_start();
    check("start_vld", {31'h0, tx_vld}, 32'h1);
    check("start_busy", {31'h0, busy}, 32'h1);
    check("start_hdr0", {24'h0, tx_data}, 32'h55);
    wait_for(0, 200, 1'b1, 0);
    check("f1_busy", {31'h0, busy}, 32'h0);
    check("f1_seq", {24'h0, seq}, 32'h1);
    check("f1_done_cnt", done_cnt, 1);

    // Back-to-back frame started in the frame_done cycle
    p1 = 16'hFFFF; p2 = 16'hFFFF; p3 = 16'hFFFF;
    push_vec(80'h55AA_01FF_FFFF_FFFF_FFFB, 10);
    pulse_start();
    check("b2b_vld", {31'h0, tx_vld}, 32'h1);
    wait_for(0, 200, 1'b0, 0);
    check("f2_seq", {24'h0, seq}, 32'h2);
    check("f2_ovf", {24'h0, ovf_cnt}, 32'h0);
    tick();

    // Overrun: two pulses mid-frame, one in the final tx_done_sig cycle
    p1 = 16'h0102; p2 = 16'h0304; p3 = 16'h0506;
    push_vec(80'h55AA_0201_0203_0405_0617, 10);
    base = mon_bytes;
    pulse_start();
    tick(); tick();
    pulse_start();
    tick(); tick(); tick();
    pulse_start();
    wait_for(2, 200, 1'b0, base);
    pulse_start();
    check("f3_done", {31'h0, frame_done}, 32'h1);
    check("f3_busy", {31'h0, busy}, 32'h0);
    check("f3_ovf", {24'h0, ovf_cnt}, 32'h3);
    check("f3_seq", {24'h0, seq}, 32'h3);
    tick(); tick(); tick();
    check("f3_dropped_idle", {31'h0, busy}, 32'h0);

    // Saturation: start held high for 300 cycles during a slow frame
    lat = 40;
    p1 = 16'h0000; p2 = 16'h0000; p3 = 16'h0000;
    push_vec(80'h55AA_0300_0000_0000_0003, 10);
    pulse_start();
    start = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    start = 1'b0;
    check("sat_ovf", {24'h0, ovf_cnt}, 32'hFF);
    wait_for(0, 600, 1'b0, 0);
    check("f4_seq", {24'h0, seq}, 32'h4);
    lat = 5;
    tick(); tick();

    // Timeout: no tx_done_sig after byte index 4
    p1 = 16'hDEAD; p2 = 16'hBEEF; p3 = 16'h0000;
    push_vec(80'h55AA_04DE_ADBE_EF00_003C, 5);
    base = mon_bytes;
    d0 = done_cnt;
    resp_left = 4;
    pulse_start();
    wait_bytes(base + 5, 200);
    t0 = cyc;
    wait_for(1, 200, 1'b0, 0);
    check("tmo_latency", cyc - t0, 51);
    check("tmo_busy", {31'h0, busy}, 32'h0);
    check("tmo_seq", {24'h0, seq}, 32'h4);
    for (int i = 0; i < 60; i++) tick();
    check("tmo_err_cnt", err_cnt, 1);
    check("tmo_no_done", done_cnt, d0);
    check("tmo_no_more_bytes", mon_bytes, base + 5);

    // Resend after timeout starts again from HDR0 with the same seq
    resp_left = 1_000_000;
    push_vec(80'h55AA_04DE_ADBE_EF00_003C, 10);
    pulse_start();
    wait_for(0, 200, 1'b0, 0);
    check("f5_seq", {24'h0, seq}, 32'h5);
    tick();

    // Reset during byte index 6
    p1 = 16'h1111; p2 = 16'h2222; p3 = 16'h3333;
    push_vec(80'h55AA_0511_1122_2233_33D1, 7);
    base = mon_bytes;
    d0 = done_cnt;
    pulse_start();
    wait_bytes(base + 7, 200);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_tx_data", {24'h0, tx_data}, 32'h0);
    check("mrst_tx_vld", {31'h0, tx_vld}, 32'h0);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    check("mrst_seq", {24'h0, seq}, 32'h0);
    check("mrst_ovf", {24'h0, ovf_cnt}, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    check("mrst_no_done", done_cnt, d0);
    check("mrst_no_err", err_cnt, 1);
    check("mrst_no_bytes", mon_bytes, base + 7);

    // Frame after reset uses seq 0
    p1 = 16'h0001; p2 = 16'h0002; p3 = 16'h0003;
    push_vec(80'h55AA_0000_0100_0200_0306, 10);
    pulse_start();
    wait_for(0, 200, 1'b0, 0);
    check("f7_seq", {24'h0, seq}, 32'h1);
    tick(); tick();
    check("queue_empty", exp_q.size(), 0);
    check("total_done", done_cnt, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
